// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU and DBG requesters. The command stage is registered.
// Read data is routed back to the port that issued the read. CPU has priority, but a
// consecutive-grant limit guarantees that a waiting DBG request is served.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic          m_rd,
    output logic          m_wr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [3:0]    run_cnt_q, run_cnt_d;
    logic          owner_q, owner_d;
    logic          pend_q, pend_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          m_rd_q, m_rd_d;
    logic          m_wr_q, m_wr_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          burst_full;

    // DBG wins a contested cycle only once the CPU has used up its burst allowance.
    always_comb begin
        burst_full = (run_cnt_q >= BURST_LIM);
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        if (rst) begin
            c_gnt = c_req && !(d_req && burst_full);
            d_gnt = d_req && !c_gnt;
        end
    end

    always_comb begin
        run_cnt_d  = run_cnt_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_rd_d     = 1'b0;
        m_wr_d     = 1'b0;
        owner_d    = owner_q;
        pend_d     = 1'b0;

        if (!d_req || d_gnt) begin
            run_cnt_d = '0;
        end else if (c_gnt && !burst_full) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end

        if (c_gnt) begin
            m_addr_d  = c_addr;
            m_wdata_d = c_wdata;
            m_rd_d    = !c_wr;
            m_wr_d    = c_wr;
            owner_d   = 1'b0;
            pend_d    = !c_wr;
        end else if (d_gnt) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_rd_d    = !d_wr;
            m_wr_d    = d_wr;
            owner_d   = 1'b1;
            pend_d    = !d_wr;
        end

        // Memory returns data the cycle after m_rd, which is when the pending flag is seen here.
        c_rvalid_d = pend_q && !owner_q;
        d_rvalid_d = pend_q && owner_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q  <= '0;
            owner_q    <= 1'b0;
            pend_q     <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_rd_q     <= 1'b0;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            owner_q    <= owner_d;
            pend_q     <= pend_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_rd     = m_rd_q;
    assign m_wr     = m_wr_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
